// File: rtl/uart_frame_rx_ctrl.sv
// 8x-oversampled 11-bit frame receiver (start, 8 data LSB-first, parity, stop)
// with a one-deep byte buffer and a valid/ack handshake toward the consumer.
module uart_frame_rx_ctrl #(
   parameter int CLK_DIV    = 24,
   parameter int OVERSAMPLE = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk_1M8,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rd_ack,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int TW = $clog2(OVERSAMPLE);

   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
   localparam logic [TW-1:0] T_S0    = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_S1    = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_S2    = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_END   = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   state_t state;
   state_t state_nx;

   logic          rx_meta;
   logic          rx_s;
   logic          rx_prev;
   logic          fall;
   logic [PW-1:0] presc;
   logic          tick;
   logic [TW-1:0] tck;
   logic          smp_a;
   logic          smp_b;
   logic          maj;
   logic          dec;
   logic          bit_end;
   logic          start_go;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [PW-1:0] hi_cnt;
   logic          hi_done;
   logic          load;
   logic          load_ok;
   logic          perr_new;

   assign fall     = rx_prev & ~rx_s;
   assign tick     = (presc == PRE_MAX);
   assign dec      = tick && (tck == T_S2);
   assign bit_end  = tick && (tck == T_END);
   assign start_go = (state == IDLE) && fall;
   assign maj      = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
   assign hi_done  = rx_s && (hi_cnt == PRE_MAX);
   assign load     = (state == STOP) && dec;
   assign load_ok  = !rx_valid || rd_ack;
   assign perr_new = ((^shreg) ^ par_bit) != PARITY_ODD;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk_1M8 or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // Start edge re-phases the bit timing to the frame.
   always_ff @(posedge clk_1M8 or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         tck   <= '0;
      end else if (start_go) begin
         presc <= '0;
         tck   <= '0;
      end else if (tick) begin
         presc <= '0;
         tck   <= (tck == T_END) ? '0 : tck + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_ff @(posedge clk_1M8 or negedge rst_n) begin
      if (!rst_n) begin
         smp_a <= 1'b0;
         smp_b <= 1'b0;
      end else if (tick) begin
         if (tck == T_S0) smp_a <= rx_s;
         if (tck == T_S1) smp_b <= rx_s;
      end
   end

   always_ff @(posedge clk_1M8 or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (fall) state_nx = START;
         end
         START: begin
            if (dec && maj)   state_nx = IDLE;
            else if (bit_end) state_nx = DATA;
         end
         DATA: begin
            if (bit_end && bit_cnt == 3'd7) state_nx = PARITY;
         end
         PARITY: begin
            if (bit_end) state_nx = STOP;
         end
         STOP: begin
            if (dec) state_nx = maj ? IDLE : BREAK;
         end
         BREAK: begin
            if (hi_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_1M8 or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         if (state == START && bit_end) bit_cnt <= '0;
         if (state == DATA && bit_end)  bit_cnt <= bit_cnt + 1'b1;
         if (state == DATA && dec)      shreg   <= {maj, shreg[7:1]};
         if (state == PARITY && dec)    par_bit <= maj;
      end
   end

   // Line must stay high a full tick before a break is considered over.
   always_ff @(posedge clk_1M8 or negedge rst_n) begin
      if (!rst_n)                        hi_cnt <= '0;
      else if (state != BREAK || !rx_s) hi_cnt <= '0;
      else if (!hi_done)                hi_cnt <= hi_cnt + 1'b1;
   end

   always_ff @(posedge clk_1M8 or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else if (load && load_ok) begin
         rx_data    <= shreg;
         rx_valid   <= 1'b1;
         parity_err <= perr_new;
         frame_err  <= ~maj;
      end else if (rd_ack && rx_valid) begin
         rx_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk_1M8 or negedge rst_n) begin
      if (!rst_n)                 overrun <= 1'b0;
      else if (load && !load_ok) overrun <= 1'b1;
      else if (rd_ack)           overrun <= 1'b0;
   end

endmodule

// File: tb/tb_uart_frame_rx_ctrl.sv
// Directed bench for uart_frame_rx_ctrl; expected bytes/flags are queued
// as each frame is driven and popped when rx_valid appears.
module tb_uart_frame_rx_ctrl;

   localparam int BIT_CLKS = 192;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rd_ack;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } want_t;

   want_t sb[$];

   uart_frame_rx_ctrl #(
      .CLK_DIV(24),
      .OVERSAMPLE(8),
      .PARITY_ODD(1'b0)
   ) dut (
      .clk_1M8(clk),
      .rst_n(rst_n),
      .rx(rx),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rd_ack(rd_ack),
      .parity_err(parity_err),
      .frame_err(frame_err),
      .overrun(overrun),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      clks(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p,
                             input logic st, input bit push);
      want_t w;
      if (push) begin
         w.d  = d;
         w.pe = (^d) ^ p;
         w.fe = ~st;
         sb.push_back(w);
      end
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(st);
   endtask

   task automatic expect_byte(input string tag);
      want_t w;
      int n = 0;
      while (!rx_valid && n < 400) begin
         clks(1);
         n++;
      end
      check({tag, "_valid"}, 8'(rx_valid), 8'd1);
      check({tag, "_sb"}, 8'(sb.size() != 0), 8'd1);
      if (sb.size() != 0) begin
         w = sb.pop_front();
         check({tag, "_data"}, rx_data, w.d);
         check({tag, "_perr"}, 8'(parity_err), 8'(w.pe));
         check({tag, "_ferr"}, 8'(frame_err), 8'(w.fe));
      end
   endtask

   task automatic ack();
      rd_ack = 1'b1;
      clks(1);
      rd_ack = 1'b0;
      clks(1);
   endtask

   initial begin
      rst_n  = 1'b0;
      rx     = 1'b1;
      rd_ack = 1'b0;
      clks(5);
      check("rst_data", rx_data, 8'h00);
      check("rst_valid", 8'(rx_valid), 8'd0);
      check("rst_perr", 8'(parity_err), 8'd0);
      check("rst_ferr", 8'(frame_err), 8'd0);
      check("rst_ovr", 8'(overrun), 8'd0);
      check("rst_busy", 8'(busy), 8'd0);
      rst_n = 1'b1;
      clks(50);

      // good frame
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      expect_byte("t1");
      check("t1_busy", 8'(busy), 8'd0);
      ack();
      check("t1_ack", 8'(rx_valid), 8'd0);

      // bad parity, then a good frame clears it
      send_frame(8'h01, 1'b0, 1'b1, 1'b1);
      expect_byte("t2a");
      ack();
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      expect_byte("t2b");
      ack();

      // framing error with line held low
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      clks(1000);
      expect_byte("t3");
      check("t3_busy_lo", 8'(busy), 8'd1);
      rx = 1'b1;
      clks(10);
      check("t3_busy_hi10", 8'(busy), 8'd1);
      clks(40);
      check("t3_busy_hi50", 8'(busy), 8'd0);
      ack();
      send_frame(8'h55, 1'b0, 1'b1, 1'b1);
      expect_byte("t3b");
      ack();

      // start glitch
      rx = 1'b0;
      clks(40);
      rx = 1'b1;
      clks(20);
      check("t4_busy", 8'(busy), 8'd1);
      clks(200);
      check("t4_idle", 8'(busy), 8'd0);
      check("t4_novalid", 8'(rx_valid), 8'd0);

      // overrun: second frame discarded
      send_frame(8'h11, 1'b0, 1'b1, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      expect_byte("t5");
      check("t5_ovr", 8'(overrun), 8'd1);
      ack();
      check("t5_ack_valid", 8'(rx_valid), 8'd0);
      check("t5_ack_ovr", 8'(overrun), 8'd0);

      // reset mid-frame with an unread byte pending
      send_frame(8'h66, 1'b0, 1'b1, 1'b1);
      expect_byte("t6a");
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      clks(50);
      check("t6_busy_pre", 8'(busy), 8'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 8'(rx_valid), 8'd0);
      check("t6_rst_data", rx_data, 8'h00);
      check("t6_rst_busy", 8'(busy), 8'd0);
      check("t6_rst_ovr", 8'(overrun), 8'd0);
      clks(3);
      rx    = 1'b1;
      rst_n = 1'b1;
      clks(300);
      send_frame(8'h81, 1'b0, 1'b1, 1'b1);
      expect_byte("t6b");
      check("t6_ovr", 8'(overrun), 8'd0);
      ack();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
